// File: rtl/result_uart_tx.sv
// result_uart_tx
//   Streams filter result samples out of an 8N1 UART in framed form:
//   header 0xA5, then FRAME_LEN samples as HI/LO byte pairs, then an
//   8-bit XOR checksum over all sample bytes.
//
// Parameters
//   DATA_W    : filter sample width (1..16), zero-extended to 16 bits
//   CLK_DIV   : clock cycles per UART bit (>= 2)
//   FRAME_LEN : samples per frame (1..255)
//
// Ports
//   clk          : system clock, rising edge
//   reset_lo     : asynchronous active-low reset
//   tx_en        : level; frames are sent back-to-back while high
//   filter_vaild : sample request to the filter output FIFO (REQ state only)
//   filter_ready : filter_data valid this cycle
//   filter_data  : filter result sample
//   txd          : UART serial line, idle high
//   busy         : high whenever the FSM is not idle
//   frame_done   : one-cycle pulse at the end of each frame
module result_uart_tx #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned CLK_DIV   = 434,
   parameter int unsigned FRAME_LEN = 64
) (
   input  logic              clk,
   input  logic              reset_lo,
   input  logic              tx_en,
   output logic              filter_vaild,
   input  logic              filter_ready,
   input  logic [DATA_W-1:0] filter_data,
   output logic              txd,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned       BAUD_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLK_DIV - 1);
   localparam logic [3:0]        BIT_LAST    = 4'd9;
   localparam logic [7:0]        FRAME_LEN_8 = 8'(FRAME_LEN);
   localparam logic [7:0]        HDR_BYTE    = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      REQ,
      HI,
      LO,
      CSUM,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [BAUD_W-1:0] baud_cnt;
   logic [3:0]        bit_cnt;
   logic [7:0]        sample_cnt;
   logic [15:0]       holding;
   logic [7:0]        csum;

   logic [15:0]       data_ext;
   logic              xfer;
   logic              in_byte;
   logic              byte_end;
   logic [7:0]        tx_byte;
   logic              line_nxt;

   // ------------------------------------------------------------------
   // Handshake and byte timing helpers
   // ------------------------------------------------------------------
   always_comb begin
      data_ext               = '0;
      data_ext[DATA_W-1:0]   = filter_data;
   end

   assign xfer     = (state == REQ) && filter_ready;
   assign in_byte  = (state == HDR) || (state == HI) || (state == LO) || (state == CSUM);
   assign byte_end = in_byte && (bit_cnt == BIT_LAST) && (baud_cnt == BAUD_LAST);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_lo) begin
      if (!reset_lo) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (tx_en) begin
               state_nxt = HDR;
            end
         end
         HDR: begin
            if (byte_end) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (xfer) begin
               state_nxt = HI;
            end
         end
         HI: begin
            if (byte_end) begin
               state_nxt = LO;
            end
         end
         LO: begin
            // sample_cnt already includes the sample being sent
            if (byte_end) begin
               state_nxt = (sample_cnt < FRAME_LEN_8) ? REQ : CSUM;
            end
         end
         CSUM: begin
            if (byte_end) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = tx_en ? HDR : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      filter_vaild = 1'b0;
      busy         = 1'b1;
      frame_done   = 1'b0;
      unique case (state)
         IDLE:    busy         = 1'b0;
         REQ:     filter_vaild = 1'b1;
         DONE:    frame_done   = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Byte source and serial bit selection
   // ------------------------------------------------------------------
   always_comb begin
      tx_byte = '0;
      unique case (state)
         HDR:     tx_byte = HDR_BYTE;
         HI:      tx_byte = holding[15:8];
         LO:      tx_byte = holding[7:0];
         CSUM:    tx_byte = csum;
         default: tx_byte = '0;
      endcase
   end

   // Bit slot 0 is the start bit, 1..8 the data LSB first, 9 the stop bit.
   // txd is registered from this, which gives the one-cycle latency after
   // entering a byte state and lets the next byte start with no gap.
   always_comb begin
      line_nxt = 1'b1;
      if (in_byte) begin
         if (bit_cnt == 4'd0) begin
            line_nxt = 1'b0;
         end else if (bit_cnt == BIT_LAST) begin
            line_nxt = 1'b1;
         end else begin
            line_nxt = tx_byte[3'(bit_cnt - 4'd1)];
         end
      end
   end

   // ------------------------------------------------------------------
   // Baud and bit counters (idle at zero outside byte states)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_lo) begin
      if (!reset_lo) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (!in_byte) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (baud_cnt == BAUD_LAST) begin
         baud_cnt <= '0;
         bit_cnt  <= (bit_cnt == BIT_LAST) ? 4'd0 : bit_cnt + 4'd1;
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Serial line, sample holding, sample counter and checksum
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_lo) begin
      if (!reset_lo) begin
         txd        <= 1'b1;
         holding    <= '0;
         sample_cnt <= '0;
         csum       <= '0;
      end else begin
         txd <= line_nxt;

         if (state == HDR) begin
            sample_cnt <= '0;
            csum       <= '0;
         end

         if (xfer) begin
            holding    <= data_ext;
            sample_cnt <= sample_cnt + 8'd1;
         end

         if (byte_end && ((state == HI) || (state == LO))) begin
            csum <= csum ^ tx_byte;
         end
      end
   end

endmodule

// File: tb/tb_result_uart_tx.sv
module tb_result_uart_tx;

   logic        clk;
   logic        reset_lo;

   logic        tx_en_a;
   logic        ready_a;
   logic [15:0] data_a;
   logic        vaild_a;
   logic        txd_a;
   logic        busy_a;
   logic        done_a;

   logic        tx_en_b;
   logic        ready_b;
   logic [11:0] data_b;
   logic        vaild_b;
   logic        txd_b;
   logic        busy_b;
   logic        done_b;

   int          compared = 0;
   int          failed   = 0;
   int          fd_cnt_a = 0;
   int          fd_cnt_b = 0;

   logic [7:0]  q_a[$];
   logic [7:0]  q_b[$];

   result_uart_tx #(.DATA_W(16), .CLK_DIV(4), .FRAME_LEN(2)) dut_a (
      .clk          (clk),
      .reset_lo     (reset_lo),
      .tx_en        (tx_en_a),
      .filter_vaild (vaild_a),
      .filter_ready (ready_a),
      .filter_data  (data_a),
      .txd          (txd_a),
      .busy         (busy_a),
      .frame_done   (done_a)
   );

   result_uart_tx #(.DATA_W(12), .CLK_DIV(4), .FRAME_LEN(1)) dut_b (
      .clk          (clk),
      .reset_lo     (reset_lo),
      .tx_en        (tx_en_b),
      .filter_vaild (vaild_b),
      .filter_ready (ready_b),
      .filter_data  (data_b),
      .txd          (txd_b),
      .busy         (busy_b),
      .frame_done   (done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   function automatic logic f_txd(input int which);
      return (which == 0) ? txd_a : txd_b;
   endfunction

   function automatic logic f_vaild(input int which);
      return (which == 0) ? vaild_a : vaild_b;
   endfunction

   function automatic logic f_busy(input int which);
      return (which == 0) ? busy_a : busy_b;
   endfunction

   function automatic logic f_done(input int which);
      return (which == 0) ? done_a : done_b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset_lo && done_a) fd_cnt_a++;
      if (reset_lo && done_b) fd_cnt_b++;
   end

   // UART receiver / scoreboard monitor; aborts a byte if reset hits mid-byte
   task automatic rx_mon(input int which);
      logic       v;
      logic       first;
      logic [7:0] data;
      logic [7:0] exp;
      bit         ok_frame;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (reset_lo && f_txd(which) === 1'b0) begin
            aborted  = 0;
            ok_frame = 1;
            data     = '0;
            first    = 1'b0;
            for (int b = 0; b < 10 && !aborted; b++) begin
               for (int c = 0; c < 4 && !aborted; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  if (!reset_lo) begin
                     aborted = 1;
                  end else begin
                     v = f_txd(which);
                     if (c == 0) first = v;
                     else if (v !== first) ok_frame = 0;
                     if (b == 0 && v !== 1'b0) ok_frame = 0;
                     if (b == 9 && v !== 1'b1) ok_frame = 0;
                     if (b >= 1 && b <= 8 && c == 0) data[b-1] = v;
                  end
               end
            end
            if (!aborted) begin
               check((which == 0) ? "framing_a" : "framing_b", {31'd0, ok_frame}, 32'd1);
               if (which == 0) begin
                  if (q_a.size() == 0) begin
                     compared++;
                     failed++;
                     $display("FAIL unexpected_byte_a: got %0h expected none", data);
                  end else begin
                     exp = q_a.pop_front();
                     check("byte_a", {24'd0, data}, {24'd0, exp});
                  end
               end else begin
                  if (q_b.size() == 0) begin
                     compared++;
                     failed++;
                     $display("FAIL unexpected_byte_b: got %0h expected none", data);
                  end else begin
                     exp = q_b.pop_front();
                     check("byte_b", {24'd0, data}, {24'd0, exp});
                  end
               end
            end
         end
      end
   endtask

   initial rx_mon(0);
   initial rx_mon(1);

   // Wait for a request, optionally stall, then hand over one sample.
   task automatic supply(input int which, input logic [15:0] sample, input int stall);
      int n;
      n = 0;
      while (f_vaild(which) !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (f_vaild(which) !== 1'b1) begin
         check("vaild_timeout", {31'd0, f_vaild(which)}, 32'd1);
         return;
      end
      for (int i = 0; i < stall; i++) begin
         check("stall_vaild", {31'd0, f_vaild(which)}, 32'd1);
         check("stall_txd",   {31'd0, f_txd(which)},   32'd1);
         check("stall_busy",  {31'd0, f_busy(which)},  32'd1);
         @(negedge clk);
      end
      if (which == 0) begin
         ready_a = 1'b1;
         data_a  = sample;
      end else begin
         ready_b = 1'b1;
         data_b  = sample[11:0];
      end
      @(negedge clk);
      ready_a = 1'b0;
      ready_b = 1'b0;
      check("vaild_after_xfer", {31'd0, f_vaild(which)}, 32'd0);
   endtask

   task automatic wait_done(input int which);
      int n;
      n = 0;
      while (f_done(which) !== 1'b1 && n < 1500) begin
         @(negedge clk);
         n++;
      end
      check("frame_done_seen", {31'd0, f_done(which)}, 32'd1);
   endtask

   // Frame ends with tx_en low: expect IDLE, no further bytes.
   task automatic end_frame(input int which, input int fd_start);
      wait_done(which);
      @(negedge clk);
      check("frame_done_width", {31'd0, f_done(which)}, 32'd0);
      check("busy_after_done",  {31'd0, f_busy(which)}, 32'd0);
      repeat (60) @(negedge clk);
      check("queue_empty", (which == 0) ? q_a.size() : q_b.size(), 32'd0);
      check("idle_busy",   {31'd0, f_busy(which)}, 32'd0);
      check("idle_txd",    {31'd0, f_txd(which)},  32'd1);
      check("frame_count", (which == 0) ? (fd_cnt_a - fd_start) : (fd_cnt_b - fd_start), 32'd1);
   endtask

   initial begin : stim
      int          fd0;
      int          n;
      logic [15:0] smp_b [3];
      smp_b = '{16'h0FFF, 16'h0123, 16'h0ABC};

      reset_lo = 1'b0;
      tx_en_a  = 1'b0;
      ready_a  = 1'b0;
      data_a   = '0;
      tx_en_b  = 1'b0;
      ready_b  = 1'b0;
      data_b   = '0;

      #23;
      check("rst_txd_a",   {31'd0, txd_a},   32'd1);
      check("rst_vaild_a", {31'd0, vaild_a}, 32'd0);
      check("rst_busy_a",  {31'd0, busy_a},  32'd0);
      check("rst_done_a",  {31'd0, done_a},  32'd0);
      check("rst_txd_b",   {31'd0, txd_b},   32'd1);
      check("rst_busy_b",  {31'd0, busy_b},  32'd0);
      @(negedge clk);
      #2 reset_lo = 1'b1;
      @(negedge clk);
      check("idle_no_en_busy", {31'd0, busy_a}, 32'd0);

      // Basic frame, ready held high; tx_en drops during second sample
      fd0 = fd_cnt_a;
      q_a.push_back(8'hA5); q_a.push_back(8'h12); q_a.push_back(8'h34);
      q_a.push_back(8'hAB); q_a.push_back(8'hCD); q_a.push_back(8'h40);
      tx_en_a = 1'b1;
      ready_a = 1'b1;
      data_a  = 16'h1234;
      n = 0;
      while (vaild_a !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      check("s1_vaild1", {31'd0, vaild_a}, 32'd1);
      @(negedge clk);
      data_a = 16'hABCD;
      n = 0;
      while (vaild_a !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      check("s1_vaild2", {31'd0, vaild_a}, 32'd1);
      @(negedge clk);
      data_a  = 16'h0000;
      tx_en_a = 1'b0;
      end_frame(0, fd0);
      ready_a = 1'b0;

      // Stall in REQ for 100 cycles
      fd0 = fd_cnt_a;
      q_a.push_back(8'hA5); q_a.push_back(8'h00); q_a.push_back(8'hFF);
      q_a.push_back(8'h5A); q_a.push_back(8'h3C); q_a.push_back(8'h99);
      tx_en_a = 1'b1;
      supply(0, 16'h00FF, 100);
      supply(0, 16'h5A3C, 0);
      tx_en_a = 1'b0;
      end_frame(0, fd0);

      // Reset during bit 3 of the HI byte
      q_a.push_back(8'hA5);
      tx_en_a = 1'b1;
      supply(0, 16'h1234, 0);
      n = 0;
      while (txd_a !== 1'b0 && n < 10) begin @(negedge clk); n++; end
      check("hi_start_seen", {31'd0, txd_a}, 32'd0);
      repeat (17) @(negedge clk);
      check("hi_bit3_low", {31'd0, txd_a}, 32'd0);
      #2 reset_lo = 1'b0;
      #1;
      check("mid_rst_txd",   {31'd0, txd_a},   32'd1);
      check("mid_rst_vaild", {31'd0, vaild_a}, 32'd0);
      check("mid_rst_busy",  {31'd0, busy_a},  32'd0);
      check("mid_rst_done",  {31'd0, done_a},  32'd0);
      @(negedge clk);
      @(negedge clk);
      check("rst_held_txd", {31'd0, txd_a}, 32'd1);
      #2 reset_lo = 1'b1;
      #1;
      check("release_busy", {31'd0, busy_a}, 32'd0);
      fd0 = fd_cnt_a;
      q_a.push_back(8'hA5); q_a.push_back(8'h00); q_a.push_back(8'h01);
      q_a.push_back(8'h80); q_a.push_back(8'h00); q_a.push_back(8'h81);
      @(negedge clk);
      check("post_rst_busy", {31'd0, busy_a}, 32'd1);
      supply(0, 16'h0001, 0);
      supply(0, 16'h8000, 0);
      tx_en_a = 1'b0;
      end_frame(0, fd0);

      // DATA_W=12, FRAME_LEN=1, three back-to-back frames
      fd0 = fd_cnt_b;
      q_b.push_back(8'hA5); q_b.push_back(8'h0F); q_b.push_back(8'hFF); q_b.push_back(8'hF0);
      q_b.push_back(8'hA5); q_b.push_back(8'h01); q_b.push_back(8'h23); q_b.push_back(8'h22);
      q_b.push_back(8'hA5); q_b.push_back(8'h0A); q_b.push_back(8'hBC); q_b.push_back(8'hB6);
      tx_en_b = 1'b1;
      for (int f = 0; f < 3; f++) begin
         supply(1, smp_b[f], 0);
         if (f == 2) tx_en_b = 1'b0;
         wait_done(1);
         @(negedge clk);
         check("b_done_width", {31'd0, done_b}, 32'd0);
         if (f < 2) begin
            check("b_busy_hdr", {31'd0, busy_b}, 32'd1);
            @(negedge clk);
            check("b_a5_start", {31'd0, txd_b}, 32'd0);
         end else begin
            check("b_busy_idle", {31'd0, busy_b}, 32'd0);
         end
      end
      repeat (60) @(negedge clk);
      check("b_queue_empty", q_b.size(), 32'd0);
      check("b_frame_count", fd_cnt_b - fd0, 32'd3);
      check("b_idle_txd", {31'd0, txd_b}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
- REQ-001: Parameter DATA_W, default 16 (equal to `rdata_width), filter result sample width, legal range 1..16.
- REQ-002: Parameter CLK_DIV, default 434 (50 MHz / 115200), clock cycles per UART bit, minimum 2.
- REQ-003: Parameter FRAME_LEN, default 64, samples per frame, range 1..255.
- REQ-004: clk  input  1  single system clock; all logic on rising edge.
- REQ-005: reset_lo  input  1  asynchronous, active-low reset.
- REQ-006: tx_en  input  1  level; while high, frames are sent back-to-back.
- REQ-007: filter_vaild  output  1  sample request to the filter output FIFO.
- REQ-008: filter_ready  input  1  filter_data is valid this cycle.
- REQ-009: filter_data  input  DATA_W  filter result sample.
- REQ-010: txd  output  1  UART serial line, 8N1, idle high.
- REQ-011: busy  output  1  high whenever state is not IDLE.
- REQ-012: frame_done  output  1  one-cycle pulse after the last stop bit of a frame.

Function
- REQ-013: Transfer occurs on a cycle where filter_vaild and filter_ready are both high; filter_data is captured into a 16-bit holding register, zero-extended to 16 bits.
- REQ-014: filter_vaild is high only in state REQ; filter_ready while filter_vaild is low is ignored.
- REQ-015: States: IDLE, HDR, REQ, HI, LO, CSUM, DONE.
- REQ-016: IDLE -> HDR when tx_en is high; stays in IDLE otherwise.
- REQ-017: HDR sends byte 0xA5, then -> REQ.
- REQ-018: REQ holds filter_vaild high indefinitely until a transfer; on transfer -> HI next cycle.
- REQ-019: HI sends holding[15:8], then -> LO; LO sends holding[7:0], then -> REQ if the sample counter < FRAME_LEN, else -> CSUM.
- REQ-020: The sample counter (8 bits) clears in HDR and increments by 1 on each transfer.
- REQ-021: CSUM sends the XOR of all HI and LO bytes of the frame (header excluded), then -> DONE.
- REQ-022: DONE pulses frame_done for one cycle, then -> HDR if tx_en is high, else -> IDLE.
- REQ-023: Each byte: start bit 0, bits 0..7 LSB first, stop bit 1; each bit is exactly CLK_DIV cycles; byte duration 10*CLK_DIV cycles.
- REQ-024: The start bit of a byte drives txd on the cycle after the state is entered (one cycle of latency); no idle gap is inserted between consecutive bytes of a frame other than REQ wait time.
- REQ-025: tx_en falling mid-frame does not abort; the frame completes including CSUM and frame_done.
- REQ-026: The checksum accumulator clears in HDR; 8-bit XOR, with no carry.
- REQ-027: The bit and baud counters wrap to 0 at each bit/byte boundary; no counter overflows for legal parameters.

Reset
- REQ-028: While reset_lo is low: state = IDLE, txd = 1, filter_vaild = 0, busy = 0, frame_done = 0, all counters, the holding register and the checksum are 0.
- REQ-029: Reset asserted mid-byte forces txd high immediately (asynchronously) and discards the partial frame; after release the block waits in IDLE for tx_en.
- REQ-030: The first frame after reset release starts no earlier than the cycle after release.

Verification
- REQ-031: FRAME_LEN=2, CLK_DIV=4, tx_en=1, samples 0x1234 and 0xABCD, filter_ready always high -> txd bytes A5,12,34,AB,CD,CSUM=0x40 (0x12^0x34^0xAB^0xCD); frame_done pulses once; each bit lasts 4 cycles.
- REQ-032: Stall test: filter_ready held low for 100 cycles in REQ -> filter_vaild stays high, txd stays 1, busy stays 1; on ready with 0x00FF -> bytes 00,FF follow.
- REQ-033: DATA_W=12, sample 0xFFF -> HI=0x0F, LO=0xFF (zero extension).
- REQ-034: tx_en dropped during the second sample -> frame completes with CSUM and frame_done, then IDLE, busy=0, with no new A5 sent.
- REQ-035: reset_lo pulsed low during bit 3 of byte HI -> txd=1 in the same cycle and all outputs at reset values; after release with tx_en=1 -> a new frame starts with A5 and the counter restarts at 0.
- REQ-036: tx_en held high for 3 frames, FRAME_LEN=1 -> three frame_done pulses; the A5 of the next frame begins within 2 cycles of each DONE.
